stream_ram_loader: RTL and testbench

Synthesizable program-image loader that accepts a byte stream (object-file contents) and packs it into DATA_W-bit words with selectable byte order. It writes each word to the unified RAM through the cs/we/oe/mem_done interface at consecutive word addresses starting at BASE_ADDR. It sits between the host/boot byte source and the RAM and holds the core off until the image is loaded. It generalises word width, endianness, base address and capacity, and adds flow control, partial-word padding, a memory timeout and error reporting.

---
 rtl/stream_ram_loader.sv | 185 ++++++++++++++++++
 tb/tb_stream_ram_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_ram_loader.sv
// Packs an incoming byte stream into DATA_W-bit words and writes them to RAM at
// consecutive word addresses from BASE_ADDR, holding busy until the image is loaded.
module stream_ram_loader #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter bit                BIG_ENDIAN = 1'b0,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                MAX_WORDS  = 1024,
  parameter int                TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_input,
  output logic              cs,
  output logic              we,
  output logic              oe,
  input  logic              mem_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] word_count
);

  localparam int BPW    = DATA_W / 8;
  localparam int LANE_W = $clog2(BPW + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(BPW - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] MAX_WORDS_C = ADDR_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FINISH,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_OVERFLOW = 2'd2
  } err_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q,  lane_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [TMO_W-1:0]    tmo_q,   tmo_d;
  logic                last_q,  last_d;
  logic                done_q,  done_d;
  logic                error_q, error_d;
  err_t                err_q,   err_d;
  logic [LANE_W-1:0]   lane_pos;

  // The first byte of a word lands in the least or most significant lane.
  assign lane_pos = BIG_ENDIAN ? (LANE_LAST - lane_q) : lane_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    lane_d  = lane_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    last_d  = last_q;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = ERR_NONE;
          count_d = '0;
          addr_d  = BASE_ADDR;
          lane_d  = '0;
          data_d  = '0;
          last_d  = 1'b0;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (byte_valid) begin
          if (count_q == MAX_WORDS_C) begin
            // Capacity exhausted: the byte is consumed but never written.
            err_d   = ERR_OVERFLOW;
            state_d = S_FAULT;
          end else begin
            for (int i = 0; i < BPW; i++) begin
              if (lane_pos == LANE_W'(i)) data_d[8*i +: 8] = byte_data;
            end
            lane_d = lane_q + 1'b1;
            last_d = byte_last;
            if (byte_last || lane_q == LANE_LAST) begin
              tmo_d   = '0;
              state_d = S_WRITE;
            end
          end
        end
      end

      S_WRITE: begin
        if (mem_done) begin
          count_d = count_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          lane_d  = '0;
          data_d  = '0;
          state_d = last_q ? S_FINISH : S_COLLECT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_FAULT: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      data_q  <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      tmo_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode directly from state so they drop the cycle after leaving WRITE.
  assign byte_ready = (state_q == S_COLLECT);
  assign cs         = (state_q == S_WRITE);
  assign we         = (state_q == S_WRITE);
  assign oe         = 1'b0;
  assign busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign address    = addr_q;
  assign data_input = data_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_stream_ram_loader.sv
// Directed bench: a little-endian default loader (A) and a big-endian, base 0x100,
// two-word loader (B) share one byte stream and one RAM responder.
module tb_stream_ram_loader;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst, start, byte_valid, byte_last, mem_done;
  logic [7:0] byte_data;

  logic              rdy_a, cs_a, we_a, oe_a, busy_a, done_a, error_a;
  logic [1:0]        err_a;
  logic [ADDR_W-1:0] addr_a, wc_a;
  logic [DATA_W-1:0] data_a;

  logic              rdy_b, cs_b, we_b, oe_b, busy_b, done_b, error_b;
  logic [1:0]        err_b;
  logic [ADDR_W-1:0] addr_b, wc_b;
  logic [DATA_W-1:0] data_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_ram_loader dut_a (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy_a), .address(addr_a), .data_input(data_a),
    .cs(cs_a), .we(we_a), .oe(oe_a), .mem_done(mem_done), .busy(busy_a), .done(done_a),
    .error(error_a), .err_code(err_a), .word_count(wc_a)
  );

  stream_ram_loader #(
    .BIG_ENDIAN(1'b1), .BASE_ADDR(32'h100), .MAX_WORDS(2)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy_b), .address(addr_b), .data_input(data_b),
    .cs(cs_b), .we(we_b), .oe(oe_b), .mem_done(mem_done), .busy(busy_b), .done(done_b),
    .error(error_b), .err_code(err_b), .word_count(wc_b)
  );

  // RAM responder: completes a write mem_delay cycles after cs rises unless held off.
  int mem_delay = 1;
  bit mem_hold  = 1'b0;
  int wcnt      = 0;
  assign mem_done = cs_a && !mem_hold && (wcnt >= mem_delay);

  logic [ADDR_W-1:0] wa_addr[$], wb_addr[$];
  logic [DATA_W-1:0] wa_data[$], wb_data[$];
  int                wa_hold[$];
  int                run_a = 0, last_run_a = 0, unstable = 0;
  logic              cs_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev;
  logic [DATA_W-1:0] data_prev;

  always @(posedge clk) begin
    wcnt      <= cs_a ? wcnt + 1 : 0;
    run_a     <= cs_a ? run_a + 1 : 0;
    if (!cs_a && run_a != 0) last_run_a <= run_a;
    cs_prev   <= cs_a;
    addr_prev <= addr_a;
    data_prev <= data_a;
    if (cs_a && (rdy_a || (cs_prev && (addr_a !== addr_prev || data_a !== data_prev))))
      unstable <= unstable + 1;
    if (!rst && cs_a && we_a && mem_done) begin
      wa_addr.push_back(addr_a);
      wa_data.push_back(data_a);
      wa_hold.push_back(wcnt);
    end
    if (!rst && cs_b && we_b && mem_done) begin
      wb_addr.push_back(addr_b);
      wb_data.push_back(data_b);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_addr.delete(); wa_data.delete(); wa_hold.delete();
    wb_addr.delete(); wb_data.delete();
  endtask

  task automatic do_start();
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted by A.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    while (!rdy_a && n < 500) begin
      tick();
      n++;
    end
    if (n == 500) check("byte_ready_wait", rdy_a, 1'b1);
    tick();
    byte_last = 1'b0;
  endtask

  task automatic end_stream();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done_a || error_a) && n < budget) begin
      tick();
      n++;
    end
    if (n == budget) check("wait_end", done_a | error_a, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    tick(3);

    // Reset state
    check("rst_cs",    cs_a,   1'b0);
    check("rst_we",    we_a,   1'b0);
    check("rst_oe",    oe_a,   1'b0);
    check("rst_rdy",   rdy_a,  1'b0);
    check("rst_busy",  busy_a, 1'b0);
    check("rst_done",  done_a, 1'b0);
    check("rst_err",   error_a, 1'b0);
    check("rst_code",  err_a,  2'd0);
    check("rst_wc",    wc_a,   32'd0);
    check("rst_addr",  addr_a, 32'd0);
    check("rst_data",  data_a, 32'd0);
    check("rst_addr_b", addr_b, 32'h100);
    rst = 1'b0;
    tick();

    // One full word, LE and BE
    mem_delay = 1;
    do_start();
    check("t1_busy", busy_a, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    end_stream();
    wait_end(50);
    check("t1_nwr",    wa_addr.size(), 1);
    check("t1_addr",   wa_addr[0], 32'h0);
    check("t1_data",   wa_data[0], 32'h04030201);
    check("t1_wc",     wc_a, 32'd1);
    check("t1_done",   done_a, 1'b1);
    check("t1_err",    error_a, 1'b0);
    check("t1_busy0",  busy_a, 1'b0);
    check("t1_b_nwr",  wb_addr.size(), 1);
    check("t1_b_addr", wb_addr[0], 32'h100);
    check("t1_b_data", wb_data[0], 32'h01020304);
    check("t1_b_done", done_b, 1'b1);

    // Partial trailing word is zero-padded
    do_start();
    check("t2_done_clr", done_a, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h15, 1'b1);
    end_stream();
    wait_end(50);
    check("t2_nwr",     wa_addr.size(), 2);
    check("t2_addr0",   wa_addr[0], 32'h0);
    check("t2_data0",   wa_data[0], 32'h14131211);
    check("t2_addr1",   wa_addr[1], 32'h1);
    check("t2_data1",   wa_data[1], 32'h00000015);
    check("t2_wc",      wc_a, 32'd2);
    check("t2_done",    done_a, 1'b1);
    check("t2_b_data0", wb_data[0], 32'h11121314);
    check("t2_b_addr1", wb_addr[1], 32'h101);
    check("t2_b_data1", wb_data[1], 32'h15000000);
    check("t2_b_done",  done_b, 1'b1);

    // Slow RAM with the source holding byte_valid high
    mem_delay = 5;
    do_start();
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h25, 1'b1);
    end_stream();
    wait_end(100);
    check("t3_nwr",      wa_addr.size(), 2);
    check("t3_hold",     wa_hold[0], 5);
    check("t3_data0",    wa_data[0], 32'h24232221);
    check("t3_data1",    wa_data[1], 32'h00000025);
    check("t3_unstable", unstable, 0);
    check("t3_done",     done_a, 1'b1);

    // Memory never answers
    mem_hold = 1'b1;
    do_start();
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h34, 1'b1);
    end_stream();
    wait_end(200);
    check("t4_err",    error_a, 1'b1);
    check("t4_code",   err_a, 2'd1);
    check("t4_done",   done_a, 1'b0);
    check("t4_csrun",  last_run_a, 64);
    check("t4_wc",     wc_a, 32'd0);
    check("t4_b_code", err_b, 2'd1);
    tick(10);
    check("t4_cs",     cs_a, 1'b0);
    check("t4_nwr",    wa_addr.size(), 0);
    mem_hold = 1'b0;

    // Capacity overflow on B while A keeps loading
    mem_delay = 0;
    do_start();
    for (int i = 0; i < 12; i++) send_byte(8'(8'h41 + i), i == 11);
    end_stream();
    wait_end(100);
    check("t5_b_nwr",   wb_addr.size(), 2);
    check("t5_b_addr0", wb_addr[0], 32'h100);
    check("t5_b_data0", wb_data[0], 32'h41424344);
    check("t5_b_data1", wb_data[1], 32'h45464748);
    check("t5_b_err",   error_b, 1'b1);
    check("t5_b_code",  err_b, 2'd2);
    check("t5_b_done",  done_b, 1'b0);
    check("t5_b_wc",    wc_b, 32'd2);
    check("t5_b_rdy",   rdy_b, 1'b0);
    check("t5_nwr",     wa_addr.size(), 3);
    check("t5_addr2",   wa_addr[2], 32'h2);
    check("t5_data2",   wa_data[2], 32'h4C4B4A49);
    check("t5_done",    done_a, 1'b1);

    // Reset while the second word is being written
    mem_delay = 5;
    do_start();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h51 + i), 1'b0);
    end_stream();
    check("t6_cs_pre",  cs_a, 1'b1);
    check("t6_nwr_pre", wa_addr.size(), 1);
    rst = 1'b1;
    tick();
    check("t6_cs",     cs_a, 1'b0);
    check("t6_we",     we_a, 1'b0);
    check("t6_busy",   busy_a, 1'b0);
    check("t6_wc",     wc_a, 32'd0);
    check("t6_addr",   addr_a, 32'd0);
    check("t6_addr_b", addr_b, 32'h100);
    rst = 1'b0;
    tick(8);
    check("t6_nwr", wa_addr.size(), 1);

    // Reset and start together: reset wins
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("t7_busy", busy_a, 1'b0);
    tick();
    check("t7_busy2", busy_a, 1'b0);

    // Clean reload after reset
    mem_delay = 1;
    do_start();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    send_byte(8'h64, 1'b1);
    end_stream();
    wait_end(50);
    check("t8_nwr",    wa_addr.size(), 1);
    check("t8_addr",   wa_addr[0], 32'h0);
    check("t8_data",   wa_data[0], 32'h64636261);
    check("t8_b_addr", wb_addr[0], 32'h100);
    check("t8_b_data", wb_data[0], 32'h61626364);
    check("t8_wc",     wc_a, 32'd1);
    check("t8_done",   done_a, 1'b1);
    check("t8_unstable", unstable, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
